mps_intr_ctrl: RTL and testbench

MPS_INTR_CTRL -- requirements
Module: mps_intr_ctrl

---
 rtl/mps_intr_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_mps_intr_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mps_intr_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mps_intr_ctrl
//   Interrupt aggregation controller for the serial-port block. It stretches
//   the core reset until the clock generator has been locked for RST_STRETCH
//   cycles and exposes a small register file (PENDING/ENABLE/HOLDOFF/CTRL/RAW).
//   It drives one host interrupt through an IDLE/ASSERT/HOLDOFF state machine
//   that supports level or single-pulse signalling with a programmable
//   hold-off between interrupts.
//
// Ports
//   aclk          core clock, rising edge
//   RST           asynchronous active-high reset
//   clk_locked    clock generator lock, synchronous to aclk
//   port_irq      per-port level interrupt requests [PORT_NUM]
//   reg_req       access request, held until reg_ack
//   reg_wr        1 = write, 0 = read
//   reg_addr      byte address, [4:2] decoded
//   reg_wdata     write data
//   reg_ack       one-cycle completion pulse
//   reg_rdata     read data, valid with reg_ack
//   reg_err       unmapped address flag, valid with reg_ack
//   aresetn_out   stretched active-low reset for downstream port logic
//   intr_request  aggregated interrupt towards the host synchroniser
// -----------------------------------------------------------------------------

// Protocol checks kept apart from the datapath; instantiated by the top.
module mps_intr_ctrl_chk (
  input logic aclk,
  input logic RST,
  input logic aresetn_out,
  input logic intr_request,
  input logic reg_ack,
  input logic reg_err
);

  ack_pulse_a : assert property (@(posedge aclk) disable iff (RST)
    reg_ack |=> !reg_ack);

  err_with_ack_a : assert property (@(posedge aclk) disable iff (RST)
    reg_err |-> reg_ack);

  // One edge of slack: the edge that drops aresetn_out still sees the old FSM.
  quiet_in_reset_a : assert property (@(posedge aclk) disable iff (RST)
    (!aresetn_out && $past(!aresetn_out)) |-> !intr_request);

endmodule

module mps_intr_ctrl #(
  parameter int unsigned PORT_NUM    = 8,
  parameter int unsigned RST_STRETCH = 64,
  parameter int unsigned HOLDOFF_W   = 16
) (
  input  logic                aclk,
  input  logic                RST,
  input  logic                clk_locked,
  input  logic [PORT_NUM-1:0] port_irq,
  input  logic                reg_req,
  input  logic                reg_wr,
  input  logic [4:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  output logic                reg_ack,
  output logic [31:0]         reg_rdata,
  output logic                reg_err,
  output logic                aresetn_out,
  output logic                intr_request
);

  localparam int unsigned STRETCH_W = $clog2(RST_STRETCH + 1);
  localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(RST_STRETCH - 1);
  localparam logic [STRETCH_W-1:0] STRETCH_ONE  = STRETCH_W'(1);
  localparam logic [HOLDOFF_W-1:0] HOLD_ONE     = HOLDOFF_W'(1);
  localparam logic [HOLDOFF_W-1:0] HOLD_ZERO    = HOLDOFF_W'(0);

  // Register map index (reg_addr[4:2])
  localparam logic [2:0] IDX_PENDING = 3'd0;
  localparam logic [2:0] IDX_ENABLE  = 3'd1;
  localparam logic [2:0] IDX_HOLDOFF = 3'd2;
  localparam logic [2:0] IDX_CTRL    = 3'd3;
  localparam logic [2:0] IDX_RAW     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [STRETCH_W-1:0] stretch_cnt_r;
  logic                 aresetn_r;
  logic                 srst_s;

  logic                 ack_r;
  logic [31:0]          rdata_r;
  logic                 err_r;
  logic                 acc_s;
  logic                 wr_s;
  logic [2:0]           idx_s;
  logic [31:0]          rd_data_s;
  logic                 rd_err_s;

  logic                 wr_pend_s;
  logic                 wr_en_s;
  logic                 wr_hold_s;
  logic                 wr_ctrl_s;
  logic [PORT_NUM-1:0]  pend_clr_s;

  logic [PORT_NUM-1:0]  pend_r;
  logic [PORT_NUM-1:0]  en_r;
  logic [HOLDOFF_W-1:0] holdoff_r;
  logic                 gen_r;
  logic                 mode_r;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [HOLDOFF_W-1:0] hold_cnt_r;
  logic                 hold_load_s;
  logic                 act_s;
  logic                 gen_off_s;
  logic                 intr_r;

  logic                 unused_s;

  // ---------------------------------------------------------------------------
  // Reset stretcher
  // ---------------------------------------------------------------------------
  // Count locked cycles after reset release; any loss of lock restarts it.
  always_ff @(posedge aclk or posedge RST) begin
    if (RST) begin
      stretch_cnt_r <= '0;
      aresetn_r     <= 1'b0;
    end else if (!clk_locked) begin
      stretch_cnt_r <= '0;
      aresetn_r     <= 1'b0;
    end else if (!aresetn_r) begin
      if (stretch_cnt_r == STRETCH_LAST) begin
        aresetn_r <= 1'b1;
      end else begin
        stretch_cnt_r <= stretch_cnt_r + STRETCH_ONE;
      end
    end else begin
      stretch_cnt_r <= stretch_cnt_r;
      aresetn_r     <= aresetn_r;
    end
  end

  // Everything below RST is also held in reset while downstream reset is low.
  assign srst_s = ~aresetn_r;

  // ---------------------------------------------------------------------------
  // Register access decode
  // ---------------------------------------------------------------------------
  // A request is taken only when no ack is outstanding, so each access
  // completes exactly once even though reg_req is still high in that cycle.
  assign acc_s = reg_req & ~ack_r;
  assign wr_s  = acc_s & reg_wr & aresetn_r;
  assign idx_s = reg_addr[4:2];

  assign wr_pend_s = wr_s & (idx_s == IDX_PENDING);
  assign wr_en_s   = wr_s & (idx_s == IDX_ENABLE);
  assign wr_hold_s = wr_s & (idx_s == IDX_HOLDOFF);
  assign wr_ctrl_s = wr_s & (idx_s == IDX_CTRL);

  assign pend_clr_s = wr_pend_s ? reg_wdata[PORT_NUM-1:0] : {PORT_NUM{1'b0}};

  // Read mux and unmapped-address detection.
  always_comb begin
    rd_data_s = 32'd0;
    rd_err_s  = 1'b0;
    case (idx_s)
      IDX_PENDING: rd_data_s[PORT_NUM-1:0]  = pend_r;
      IDX_ENABLE:  rd_data_s[PORT_NUM-1:0]  = en_r;
      IDX_HOLDOFF: rd_data_s[HOLDOFF_W-1:0] = holdoff_r;
      IDX_CTRL:    rd_data_s[1:0]           = {mode_r, gen_r};
      IDX_RAW:     rd_data_s[PORT_NUM-1:0]  = port_irq;
      default:     rd_err_s                 = 1'b1;
    endcase
  end

  // Completion pulse; during internal reset accesses still finish but return 0.
  always_ff @(posedge aclk or posedge RST) begin
    if (RST) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else if (acc_s) begin
      ack_r <= 1'b1;
      if (srst_s) begin
        rdata_r <= 32'd0;
        err_r   <= 1'b0;
      end else begin
        rdata_r <= reg_wr ? 32'd0 : rd_data_s;
        err_r   <= rd_err_s;
      end
    end else begin
      ack_r   <= 1'b0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  // PENDING: a live request wins over a write-1-to-clear in the same cycle.
  always_ff @(posedge aclk or posedge RST) begin
    if (RST) begin
      pend_r    <= {PORT_NUM{1'b0}};
      en_r      <= {PORT_NUM{1'b0}};
      holdoff_r <= HOLD_ZERO;
      gen_r     <= 1'b0;
      mode_r    <= 1'b0;
    end else if (srst_s) begin
      pend_r    <= {PORT_NUM{1'b0}};
      en_r      <= {PORT_NUM{1'b0}};
      holdoff_r <= HOLD_ZERO;
      gen_r     <= 1'b0;
      mode_r    <= 1'b0;
    end else begin
      pend_r    <= (pend_r & ~pend_clr_s) | port_irq;
      en_r      <= wr_en_s   ? reg_wdata[PORT_NUM-1:0]  : en_r;
      holdoff_r <= wr_hold_s ? reg_wdata[HOLDOFF_W-1:0] : holdoff_r;
      gen_r     <= wr_ctrl_s ? reg_wdata[0]             : gen_r;
      mode_r    <= wr_ctrl_s ? reg_wdata[1]             : mode_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt state machine
  // ---------------------------------------------------------------------------
  assign act_s     = gen_r & (|(pend_r & en_r));
  // Clearing GEN takes effect on the same edge that commits the write.
  assign gen_off_s = wr_ctrl_s & ~reg_wdata[0];

  // Next-state logic; the hold-off counter is loaded on entry to HOLDOFF.
  always_comb begin
    state_nxt_s = state_r;
    hold_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (act_s) begin
          state_nxt_s = ST_ASSERT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        // Pulse mode leaves after one cycle; level mode waits for act to drop.
        if (mode_r || !act_s) begin
          if (holdoff_r == HOLD_ZERO) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_HOLDOFF;
            hold_load_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_ASSERT;
        end
      end
      ST_HOLDOFF: begin
        // Leaving on the edge that takes the count from 1 to 0.
        if (hold_cnt_r <= HOLD_ONE) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLDOFF;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (gen_off_s || !gen_r) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register with registered interrupt output.
  always_ff @(posedge aclk or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      intr_r  <= 1'b0;
    end else if (srst_s) begin
      state_r <= ST_IDLE;
      intr_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      intr_r  <= (state_nxt_s == ST_ASSERT);
    end
  end

  // Hold-off down-counter; later HOLDOFF writes only matter at the next load.
  always_ff @(posedge aclk or posedge RST) begin
    if (RST) begin
      hold_cnt_r <= HOLD_ZERO;
    end else if (srst_s) begin
      hold_cnt_r <= HOLD_ZERO;
    end else if (hold_load_s) begin
      hold_cnt_r <= holdoff_r;
    end else if ((state_r == ST_HOLDOFF) && (hold_cnt_r != HOLD_ZERO)) begin
      hold_cnt_r <= hold_cnt_r - HOLD_ONE;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign reg_ack      = ack_r;
  assign reg_rdata    = rdata_r;
  assign reg_err      = err_r;
  assign aresetn_out  = aresetn_r;
  assign intr_request = intr_r;

  // Byte-lane bits of the address and upper write-data bits are don't-care.
  assign unused_s = ^{reg_addr[1:0], reg_wdata};

  mps_intr_ctrl_chk u_chk (
    .aclk         (aclk),
    .RST          (RST),
    .aresetn_out  (aresetn_r),
    .intr_request (intr_r),
    .reg_ack      (ack_r),
    .reg_err      (err_r)
  );

endmodule

// File: tb/tb_mps_intr_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for mps_intr_ctrl: register responses go through a
// scoreboard queue consumed by a monitor; timing of aresetn_out and
// intr_request is checked against hand-computed cycle positions.
module tb_mps_intr_ctrl;

  logic        aclk = 1'b0;
  logic        RST;
  logic        clk_locked;
  logic [7:0]  port_irq;
  logic        reg_req;
  logic        reg_wr;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack;
  logic [31:0] reg_rdata;
  logic        reg_err;
  logic        aresetn_out;
  logic        intr_request;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        is_rd;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  mps_intr_ctrl dut (
    .aclk         (aclk),
    .RST          (RST),
    .clk_locked   (clk_locked),
    .port_irq     (port_irq),
    .reg_req      (reg_req),
    .reg_wr       (reg_wr),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_ack      (reg_ack),
    .reg_rdata    (reg_rdata),
    .reg_err      (reg_err),
    .aresetn_out  (aresetn_out),
    .intr_request (intr_request)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack consumes one expected response.
  always @(negedge aclk) begin
    exp_t e;
    if (reg_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_err"}, 32'(reg_err), 32'(e.err));
        if (e.is_rd) check({e.name, "_rdata"}, reg_rdata, e.rdata);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic do_req(input string name);
    int n;
    // A request raised during an ack cycle would not be taken until later.
    if (reg_ack === 1'b1) cyc(1);
    reg_req = 1'b1;
    n = 0;
    do begin
      @(posedge aclk);
      #1;
      n++;
    end while (reg_ack !== 1'b1 && n < 8);
    reg_req = 1'b0;
    check({name, "_latency"}, 32'(n), 32'd1);
  endtask

  task automatic reg_rd(input string name, input logic [4:0] addr,
                        input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    e.rdata = exp_data; e.err = exp_err; e.is_rd = 1'b1; e.name = name;
    exp_q.push_back(e);
    reg_wr = 1'b0; reg_addr = addr; reg_wdata = 32'd0;
    do_req(name);
  endtask

  task automatic reg_wr_t(input string name, input logic [4:0] addr,
                          input logic [31:0] data, input logic exp_err);
    exp_t e;
    e.rdata = 32'd0; e.err = exp_err; e.is_rd = 1'b0; e.name = name;
    exp_q.push_back(e);
    reg_wr = 1'b1; reg_addr = addr; reg_wdata = data;
    do_req(name);
  endtask

  // Called #1 after the edge on which reset/lock was released.
  task automatic stretch_check(input string name);
    for (int i = 1; i <= 64; i++) begin
      @(posedge aclk);
      #1;
      if (i == 63) check({name, "_low63"}, 32'(aresetn_out), 32'd0);
      if (i == 64) check({name, "_high64"}, 32'(aresetn_out), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; clk_locked = 1'b0; port_irq = 8'h00;
    reg_req = 1'b0; reg_wr = 1'b0; reg_addr = 5'h00; reg_wdata = 32'd0;
    cyc(3);
    check("rst_aresetn", 32'(aresetn_out), 32'd0);
    check("rst_intr",    32'(intr_request), 32'd0);
    check("rst_ack",     32'(reg_ack), 32'd0);
    check("rst_rdata",   reg_rdata, 32'd0);
    check("rst_err",     32'(reg_err), 32'd0);

    // RST released but no lock: held in internal reset, accesses return 0.
    RST = 1'b0;
    cyc(2);
    check("nolock_aresetn", 32'(aresetn_out), 32'd0);
    port_irq = 8'h05;
    reg_rd("srst_raw", 5'h10, 32'd0, 1'b0);
    reg_wr_t("srst_wr_en", 5'h04, 32'h000000FF, 1'b0);
    reg_rd("srst_en", 5'h04, 32'd0, 1'b0);
    reg_rd("srst_unmapped", 5'h18, 32'd0, 1'b0);
    port_irq = 8'h00;
    cyc(1);
    clk_locked = 1'b1;
    stretch_check("stretch1");

    // Lock lost at cycle 30 of the stretch: count must restart from zero.
    RST = 1'b1;
    cyc(2);
    check("rst_again_aresetn", 32'(aresetn_out), 32'd0);
    RST = 1'b0;
    cyc(30);
    clk_locked = 1'b0;
    cyc(1);
    check("unlock_mid_aresetn", 32'(aresetn_out), 32'd0);
    clk_locked = 1'b1;
    stretch_check("stretch2");

    // Lock lost after release: aresetn_out drops on the next edge.
    clk_locked = 1'b0;
    cyc(1);
    check("unlock_run_aresetn", 32'(aresetn_out), 32'd0);
    clk_locked = 1'b1;
    stretch_check("stretch3");

    // Unmapped addresses.
    reg_rd("rd18", 5'h18, 32'd0, 1'b1);
    cyc(1);
    check("ack_one_cycle", 32'(reg_ack), 32'd0);
    reg_rd("rd14", 5'h14, 32'd0, 1'b1);
    reg_rd("rd1c", 5'h1C, 32'd0, 1'b1);
    reg_wr_t("wr14", 5'h14, 32'hFFFFFFFF, 1'b1);

    // Register widths and address aliasing.
    reg_wr_t("wr_en", 5'h04, 32'hFFFFFFFF, 1'b0);
    reg_rd("rd_en", 5'h04, 32'h000000FF, 1'b0);
    reg_rd("rd_en_alias", 5'h07, 32'h000000FF, 1'b0);
    reg_wr_t("wr_ho", 5'h08, 32'hFFFFFFFF, 1'b0);
    reg_rd("rd_ho", 5'h08, 32'h0000FFFF, 1'b0);
    reg_wr_t("wr_ctrl_hi", 5'h0C, 32'hFFFFFFFC, 1'b0);
    reg_rd("rd_ctrl_hi", 5'h0C, 32'd0, 1'b0);
    reg_wr_t("wr_ctrl_mode", 5'h0C, 32'h00000002, 1'b0);
    reg_rd("rd_ctrl_mode", 5'h0C, 32'h00000002, 1'b0);
    reg_wr_t("wr_ctrl0", 5'h0C, 32'd0, 1'b0);
    reg_wr_t("wr_ho0", 5'h08, 32'd0, 1'b0);
    reg_wr_t("wr_en0", 5'h04, 32'd0, 1'b0);
    port_irq = 8'hA5;
    reg_rd("rd_raw", 5'h10, 32'h000000A5, 1'b0);
    port_irq = 8'h00;
    reg_rd("rd_pend", 5'h00, 32'h000000A5, 1'b0);
    reg_wr_t("clr_pend", 5'h00, 32'h000000FF, 1'b0);
    reg_rd("rd_pend_clr", 5'h00, 32'd0, 1'b0);

    // Level mode.
    reg_wr_t("lvl_en", 5'h04, 32'h00000001, 1'b0);
    reg_wr_t("lvl_ctrl", 5'h0C, 32'h00000001, 1'b0);
    port_irq = 8'h01;
    cyc(1);
    port_irq = 8'h00;
    check("lvl_intr_lat", 32'(intr_request), 32'd0);
    cyc(1);
    check("lvl_intr_on", 32'(intr_request), 32'd1);
    reg_rd("lvl_pend", 5'h00, 32'h00000001, 1'b0);
    cyc(3);
    check("lvl_intr_hold", 32'(intr_request), 32'd1);
    reg_wr_t("lvl_clr", 5'h00, 32'h00000001, 1'b0);
    check("lvl_intr_clr_edge", 32'(intr_request), 32'd1);
    cyc(1);
    check("lvl_intr_off", 32'(intr_request), 32'd0);
    reg_wr_t("lvl_gen0", 5'h0C, 32'd0, 1'b0);

    // Set and clear of PENDING in the same cycle.
    port_irq = 8'h01;
    reg_wr_t("sim_clr", 5'h00, 32'h00000001, 1'b0);
    port_irq = 8'h00;
    reg_rd("sim_pend", 5'h00, 32'h00000001, 1'b0);
    reg_wr_t("sim_clr2", 5'h00, 32'h00000001, 1'b0);
    reg_rd("sim_pend2", 5'h00, 32'd0, 1'b0);

    // Pulse mode with hold-off 10: pulses every 12 cycles.
    reg_wr_t("pls_ho", 5'h08, 32'd10, 1'b0);
    reg_wr_t("pls_ctrl", 5'h0C, 32'h00000003, 1'b0);
    port_irq = 8'h04;
    reg_wr_t("pls_en", 5'h04, 32'h00000004, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      check($sformatf("pulse%0d", i), 32'(intr_request), 32'((i % 12) == 1));
    end
    // Hold-off rewritten mid-count: current count unaffected, next uses 3.
    reg_wr_t("ho_mid", 5'h08, 32'd3, 1'b0);
    for (int i = 42; i <= 60; i++) begin
      cyc(1);
      check($sformatf("pulse%0d", i), 32'(intr_request),
            32'((i == 49) || (i == 54) || (i == 59)));
    end

    // GEN cleared: during hold-off, then during a level-mode assertion.
    reg_wr_t("gen0_ho", 5'h0C, 32'd0, 1'b0);
    check("gen0_ho_intr", 32'(intr_request), 32'd0);
    cyc(10);
    check("gen0_quiet", 32'(intr_request), 32'd0);
    reg_wr_t("gen_lvl", 5'h0C, 32'h00000001, 1'b0);
    cyc(1);
    check("lvl2_on", 32'(intr_request), 32'd1);
    cyc(2);
    check("lvl2_hold", 32'(intr_request), 32'd1);
    reg_wr_t("gen_off_assert", 5'h0C, 32'd0, 1'b0);
    check("gen_off_now", 32'(intr_request), 32'd0);

    // RST in the middle of an assertion.
    reg_wr_t("pre_rst_ctrl", 5'h0C, 32'h00000001, 1'b0);
    cyc(1);
    check("pre_rst_intr", 32'(intr_request), 32'd1);
    RST = 1'b1;
    port_irq = 8'h00;
    #1;
    check("rst_async_intr", 32'(intr_request), 32'd0);
    check("rst_async_aresetn", 32'(aresetn_out), 32'd0);
    cyc(2);
    RST = 1'b0;
    stretch_check("stretch4");
    reg_rd("post_pend", 5'h00, 32'd0, 1'b0);
    reg_rd("post_en",   5'h04, 32'd0, 1'b0);
    reg_rd("post_ho",   5'h08, 32'd0, 1'b0);
    reg_rd("post_ctrl", 5'h0C, 32'd0, 1'b0);
    reg_rd("post_raw",  5'h10, 32'd0, 1'b0);
    check("post_intr", 32'(intr_request), 32'd0);

    cyc(3);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
